command_sequencer: RTL and testbench
====================================

# command_sequencer

Multi-cycle sequencer placed between the command source (keypad/decoder) and the ULA + X/Y/Z register datapath. It accepts one 4-bit command per valid/ready handshake. It then drives the ULA operation code and the X/Y/Z register control codes over one or more clock cycles, including N-step repeated shifts for MULT/DIV. It reports busy/done/error to the front end.

## Interface
- SHIFT_W, 3, width of the shift-count input; maximum repeat count is 2^SHIFT_W-1.
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd  input  4  command: CLR 0000, CLRLD 0001, LOADX 0010, ADD 0011, SUB 0100, MULT 0101, DIV 0110, MIN 0111, MAX 1000, DISP 1001; 1010-1111 illegal.
- cmdValid  input  1  command present on cmd/shiftCount.
- shiftCount  input  SHIFT_W  number of shift steps for MULT/DIV; ignored otherwise.
- abort  input  1  synchronous cancel of an executing command.
- cmdReady  output  1  high only in IDLE; acceptance = cmdValid & cmdReady at a rising edge.
- tULA  output  3  ULA op: uADD 000, uSUB 001, uCOMP 010, uIGUAL 011, uMAIOR 100, uMENOR 101, uAND 110, uOR 111.
- tX, tY, tZ  output  3 each  register control: HOLD 000, RESET 001, LOAD 010, SHL 011, SHR 100.
- busy  output  1  high during every execution step.
- done  output  1  one-cycle completion pulse.
- err  output  1  high together with done when the completed command was illegal.

## Operation
- States: IDLE, STEP_X (X load phase), STEP_OP (ULA/Y phase), STEP_SH (shift loop), STEP_1 (single-step commands), DONE.
- Accept: latch cmd and shiftCount into internal registers; the cmd/shiftCount inputs are don't-care afterwards.
- Outputs are decoded from state and the latched command only, never from the live inputs.
- Defaults in every state unless listed: tULA=uADD, tX=tY=tZ=HOLD, busy=0, done=0, err=0.
- CLR: STEP_1 with tX=tY=tZ=RESET.
- CLRLD: STEP_1 with tX=LOAD, tY=tZ=RESET.
- LOADX: STEP_1 with tX=LOAD.
- DISP: STEP_1 with tZ=LOAD.
- ADD/SUB/MIN/MAX: first STEP_X with tX=LOAD, then STEP_OP with tY=LOAD and tULA=uADD/uSUB/uMENOR/uMAIOR respectively.
- MULT/DIV:
  - STEP_X with tX=LOAD, then STEP_SH repeated shiftCount times with tY=SHL (MULT) or SHR (DIV).
  - A down-counter loaded with shiftCount at accept, decremented each STEP_SH cycle; leave STEP_SH when the counter reaches 1.
  - shiftCount=0: skip STEP_SH, STEP_X goes directly to DONE.
- Illegal cmd: no step states; IDLE -> DONE with err=1; datapath controls stay at defaults.
- busy=1 in STEP_X, STEP_OP, STEP_SH and STEP_1.
- DONE: done=1 for exactly one cycle, then IDLE. err is 1 in DONE only for illegal commands.
- abort sampled high in any step state: next state IDLE, no done pulse, all controls HOLD from the next cycle. abort in IDLE or DONE is ignored.
- Reset (rst_n low at any time, including mid-command): immediately state=IDLE, counter=0, latched cmd=CLR. Outputs during and after reset: tULA=000, tX=tY=tZ=000, busy=0, done=0, err=0, cmdReady=1.

## Timing
- Edge E0 accepts a command.
- Step 1 controls are valid from E0 to E1; the datapath samples them at E1.
- Step count S:
  - single-step commands: 1
  - ADD/SUB/MIN/MAX: 2
  - MULT/DIV: 1+shiftCount
  - illegal: 0
- done is high in cycle E_S..E_S+1; cmdReady returns high at E_S+1.
- Throughput: one command per S+2 cycles.
- cmdValid may stay high continuously; a held command is accepted again on every IDLE cycle.
- No combinational path from cmdValid, cmd or abort to any output.

## Test plan
- Reset: hold rst_n=0 mid MULT -> all controls 000, busy=0, cmdReady=1 asynchronously. After release, IDLE with no done pulse.
- ADD accepted at E0 -> E0-E1: tX=010. E1-E2: tY=010, tULA=000. E2-E3: done=1. cmdReady high from E3.
- MULT with shiftCount=3 -> 1 cycle tX=010, then 3 consecutive cycles tY=011, then done. busy high for exactly 4 cycles.
- DIV with shiftCount=0 -> 1 cycle tX=010, no tY=100 cycle, then done=1.
- cmd=1100 -> the next cycle has done=1 and err=1, all controls HOLD, busy never asserted.
- SUB with abort=1 during STEP_X -> next cycle IDLE, tY never 010, done never asserted, cmdReady=1.

Source files
------------

// File: rtl/command_sequencer.sv
// Multi-cycle sequencer between the command front end and the ULA + X/Y/Z datapath.
// Accepts one command per valid/ready handshake and steps the datapath control codes.
module command_sequencer #(
  parameter int unsigned SHIFT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         cmd,
  input  logic               cmdValid,
  input  logic [SHIFT_W-1:0] shiftCount,
  input  logic               abort,
  output logic               cmdReady,
  output logic [2:0]         tULA,
  output logic [2:0]         tX,
  output logic [2:0]         tY,
  output logic [2:0]         tZ,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [3:0] CmdClr   = 4'b0000;
  localparam logic [3:0] CmdClrld = 4'b0001;
  localparam logic [3:0] CmdLoadx = 4'b0010;
  localparam logic [3:0] CmdAdd   = 4'b0011;
  localparam logic [3:0] CmdSub   = 4'b0100;
  localparam logic [3:0] CmdMult  = 4'b0101;
  localparam logic [3:0] CmdDiv   = 4'b0110;
  localparam logic [3:0] CmdMin   = 4'b0111;
  localparam logic [3:0] CmdMax   = 4'b1000;
  localparam logic [3:0] CmdDisp  = 4'b1001;

  localparam logic [2:0] UAdd   = 3'b000;
  localparam logic [2:0] USub   = 3'b001;
  localparam logic [2:0] UMaior = 3'b100;
  localparam logic [2:0] UMenor = 3'b101;

  localparam logic [2:0] RHold  = 3'b000;
  localparam logic [2:0] RReset = 3'b001;
  localparam logic [2:0] RLoad  = 3'b010;
  localparam logic [2:0] RShl   = 3'b011;
  localparam logic [2:0] RShr   = 3'b100;

  typedef enum logic [2:0] {
    StIdle,
    StStepX,
    StStepOp,
    StStepSh,
    StStep1,
    StDone
  } state_e;

  state_e             state_q;
  logic [3:0]         cmd_q;
  logic [SHIFT_W-1:0] cnt_q;
  logic               is_shift;

  assign is_shift = (cmd_q == CmdMult) || (cmd_q == CmdDiv);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cmd_q   <= CmdClr;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmdValid) begin
            cmd_q <= cmd;
            cnt_q <= shiftCount;
            unique case (cmd)
              CmdClr, CmdClrld, CmdLoadx, CmdDisp:         state_q <= StStep1;
              CmdAdd, CmdSub, CmdMin, CmdMax, CmdMult, CmdDiv: state_q <= StStepX;
              default:                                      state_q <= StDone;
            endcase
          end
        end
        StStepX: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (is_shift) begin
            // A zero shift count skips the shift loop entirely.
            state_q <= (cnt_q == '0) ? StDone : StStepSh;
          end else begin
            state_q <= StStepOp;
          end
        end
        StStepSh: begin
          cnt_q <= cnt_q - 1'b1;
          if (abort) begin
            state_q <= StIdle;
          end else if (cnt_q == SHIFT_W'(1)) begin
            state_q <= StDone;
          end
        end
        StStepOp, StStep1: state_q <= abort ? StIdle : StDone;
        StDone:            state_q <= StIdle;
        default:           state_q <= StIdle;
      endcase
    end
  end

  // Controls depend only on state and the latched command.
  always_comb begin
    tULA     = UAdd;
    tX       = RHold;
    tY       = RHold;
    tZ       = RHold;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    cmdReady = (state_q == StIdle);
    unique case (state_q)
      StStepX: begin
        busy = 1'b1;
        tX   = RLoad;
      end
      StStepOp: begin
        busy = 1'b1;
        tY   = RLoad;
        unique case (cmd_q)
          CmdSub:  tULA = USub;
          CmdMin:  tULA = UMenor;
          CmdMax:  tULA = UMaior;
          default: tULA = UAdd;
        endcase
      end
      StStepSh: begin
        busy = 1'b1;
        tY   = (cmd_q == CmdDiv) ? RShr : RShl;
      end
      StStep1: begin
        busy = 1'b1;
        unique case (cmd_q)
          CmdClr: begin
            tX = RReset;
            tY = RReset;
            tZ = RReset;
          end
          CmdClrld: begin
            tX = RLoad;
            tY = RReset;
            tZ = RReset;
          end
          CmdLoadx: tX = RLoad;
          CmdDisp:  tZ = RLoad;
          default:  ;
        endcase
      end
      StDone: begin
        done = 1'b1;
        err  = (cmd_q > CmdDisp);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_command_sequencer.sv
// Directed bench for command_sequencer: a vector table of whole commands plus
// hand-written reset, abort and back-to-back sequences.
module tb_command_sequencer;

  logic       clk;
  logic       rst_n;
  logic [3:0] cmd;
  logic       cmdValid;
  logic [2:0] shiftCount;
  logic       abort;
  logic       cmdReady;
  logic [2:0] tULA, tX, tY, tZ;
  logic       busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  command_sequencer #(.SHIFT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cmd),
    .cmdValid   (cmdValid),
    .shiftCount (shiftCount),
    .abort      (abort),
    .cmdReady   (cmdReady),
    .tULA       (tULA),
    .tX         (tX),
    .tY         (tY),
    .tZ         (tZ),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] c;
    logic [2:0] sc;
    int         s;
    logic [2:0] x1;
    logic [2:0] y1;
    logic [2:0] z1;
    logic [2:0] u2;
    logic [2:0] y2;
    logic       e;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present a command on the next negedge; return #1 after the accepting edge E0.
  task automatic issue(input logic [3:0] c, input logic [2:0] sc);
    @(negedge clk);
    cmd        = c;
    shiftCount = sc;
    cmdValid   = 1'b1;
    @(posedge clk);
    #1;
    cmdValid   = 1'b0;
    cmd        = 4'($urandom_range(0, 15));
    shiftCount = 3'($urandom_range(0, 7));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    cmd        = 4'h0;
    cmdValid   = 1'b0;
    shiftCount = 3'd0;
    abort      = 1'b0;

    //            cmd    sc    S  x1    y1    z1    u2    y2    err
    vecs[0]  = '{4'h0, 3'd0, 1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 1'b0};  // CLR
    vecs[1]  = '{4'h1, 3'd0, 1, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0, 1'b0};  // CLRLD
    vecs[2]  = '{4'h2, 3'd5, 1, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0};  // LOADX
    vecs[3]  = '{4'h9, 3'd0, 1, 3'd0, 3'd0, 3'd2, 3'd0, 3'd0, 1'b0};  // DISP
    vecs[4]  = '{4'h3, 3'd0, 2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd2, 1'b0};  // ADD
    vecs[5]  = '{4'h4, 3'd7, 2, 3'd2, 3'd0, 3'd0, 3'd1, 3'd2, 1'b0};  // SUB
    vecs[6]  = '{4'h7, 3'd0, 2, 3'd2, 3'd0, 3'd0, 3'd5, 3'd2, 1'b0};  // MIN
    vecs[7]  = '{4'h8, 3'd0, 2, 3'd2, 3'd0, 3'd0, 3'd4, 3'd2, 1'b0};  // MAX
    vecs[8]  = '{4'h5, 3'd3, 4, 3'd2, 3'd0, 3'd0, 3'd0, 3'd3, 1'b0};  // MULT x3
    vecs[9]  = '{4'h6, 3'd2, 3, 3'd2, 3'd0, 3'd0, 3'd0, 3'd4, 1'b0};  // DIV x2
    vecs[10] = '{4'h6, 3'd0, 1, 3'd2, 3'd0, 3'd0, 3'd0, 3'd4, 1'b0};  // DIV x0
    vecs[11] = '{4'h5, 3'd7, 8, 3'd2, 3'd0, 3'd0, 3'd0, 3'd3, 1'b0};  // MULT x7
    vecs[12] = '{4'hc, 3'd0, 0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1};  // illegal
    vecs[13] = '{4'hf, 3'd4, 0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1};  // illegal

    #12;
    chk("rst_ready", {7'd0, cmdReady}, 8'd1);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_ctrl", {tX, tY, 2'b00}, 8'd0);
    rst_n = 1'b1;
    step();
    chk("idle_done", {7'd0, done}, 8'd0);

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].c, vecs[i].sc);
      if (vecs[i].s > 0) begin
        chk($sformatf("v%0d_s1_busy", i), {6'd0, busy, cmdReady}, 8'b10);
        chk($sformatf("v%0d_s1_xyz", i), {2'b00, tX, tY[2:0] == vecs[i].y1, 2'b00},
            {2'b00, vecs[i].x1, 1'b1, 2'b00});
        chk($sformatf("v%0d_s1_zu", i), {2'b00, tZ, tULA}, {2'b00, vecs[i].z1, 3'd0});
        for (int k = 2; k <= vecs[i].s; k++) begin
          step();
          chk($sformatf("v%0d_s%0d_ctl", i, k), {tULA, tY, busy, done},
              {vecs[i].u2, vecs[i].y2, 1'b1, 1'b0});
          chk($sformatf("v%0d_s%0d_xz", i, k), {2'b00, tX, tZ}, 8'd0);
        end
        step();
      end
      chk($sformatf("v%0d_done", i), {5'd0, done, err, busy}, {5'd0, 1'b1, vecs[i].e, 1'b0});
      chk($sformatf("v%0d_done_ctl", i), {tX, tY, tZ[1:0]}, 8'd0);
      chk($sformatf("v%0d_done_rest", i), {5'd0, tZ[2], tULA == 3'd0, cmdReady}, 8'b010);
      step();
      chk($sformatf("v%0d_idle", i), {6'd0, cmdReady, done}, 8'b10);
    end

    // Asynchronous reset in the middle of a MULT shift loop.
    issue(4'h5, 3'd5);
    step();
    step();
    chk("pre_rst_shl", {5'd0, tY}, 8'd3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", {tX, tY, tZ[1:0]}, 8'd0);
    chk("async_rst_flags", {3'd0, tZ[2], tULA == 3'd0, busy, done, cmdReady}, 8'b01001);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("post_rst_%0d", k), {5'd0, busy, done, cmdReady}, 8'b001);
    end

    // Abort during STEP_X of a SUB.
    issue(4'h4, 3'd0);
    chk("abort_stepx", {5'd0, tX}, 8'd2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle", {3'd0, tY, busy, cmdReady}, 8'b00001);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("abort_quiet_%0d", k), {4'd0, tY == 3'd2, busy, done, cmdReady}, 8'b0001);
    end

    // Abort mid shift loop ends the command with no done.
    issue(4'h6, 3'd6);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_sh", {3'd0, tY, busy, done}, 8'd0);
    chk("abort_sh_ready", {7'd0, cmdReady}, 8'd1);

    // Abort held high while idle is ignored at accept time.
    @(negedge clk);
    abort = 1'b1;
    issue(4'h2, 3'd0);
    abort = 1'b0;
    chk("abort_idle_ignored", {4'd0, tX == 3'd2, busy, 2'b00}, 8'b1100);
    step();
    chk("abort_idle_done", {7'd0, done}, 8'd1);
    step();

    // Held cmdValid: LOADX re-accepted every S+2 = 3 cycles.
    @(negedge clk);
    cmd      = 4'h2;
    cmdValid = 1'b1;
    step();
    chk("held_a_step", {4'd0, tX == 3'd2, busy, 2'b00}, 8'b1100);
    step();
    chk("held_a_done", {7'd0, done}, 8'd1);
    step();
    chk("held_idle", {6'd0, cmdReady, busy}, 8'b10);
    step();
    chk("held_b_step", {4'd0, tX == 3'd2, busy, 2'b00}, 8'b1100);
    cmdValid = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
